// File: rtl/seg7_pkg.sv
// Shared segment codes, page codes and snapshot layouts for the multiplexed
// seven-segment counter display.
package seg7_pkg;

  localparam int NUM_DIGITS = 8;

  // Active-low cathode codes, bit order {g,f,e,d,c,b,a}.
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_DASH  = 7'h3F;
  localparam logic [6:0] SEG_DIGIT [0:9] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
    7'h12, 7'h02, 7'h78, 7'h00, 7'h10
  };

  localparam logic [1:0] PAGE_TOTAL  = 2'd0;
  localparam logic [1:0] PAGE_COND   = 2'd1;
  localparam logic [1:0] PAGE_UNCOND = 2'd2;

  typedef struct packed {
    logic [3:0] wan;
    logic [3:0] qian;
    logic [3:0] bai;
    logic [3:0] shi;
    logic [3:0] ge;
  } total_digits_t;

  typedef struct packed {
    logic [3:0] qian;
    logic [3:0] bai;
    logic [3:0] shi;
    logic [3:0] ge;
  } branch_digits_t;

  // Page sequence 0 -> 1 -> 2 -> 0; code 3 is never produced.
  function automatic logic [1:0] page_advance(input logic [1:0] p);
    return (p == PAGE_UNCOND) ? PAGE_TOTAL : p + 2'd1;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// BCD-to-seven-segment decoder with a blank override; non-decimal codes
// show a dash so corrupt counter digits are visible rather than hidden.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  input  logic       blank,
  output logic [6:0] code
);

  always_comb begin
    code = SEG_BLANK;
    if (!blank) begin
      case (bcd)
        4'd0:    code = SEG_DIGIT[0];
        4'd1:    code = SEG_DIGIT[1];
        4'd2:    code = SEG_DIGIT[2];
        4'd3:    code = SEG_DIGIT[3];
        4'd4:    code = SEG_DIGIT[4];
        4'd5:    code = SEG_DIGIT[5];
        4'd6:    code = SEG_DIGIT[6];
        4'd7:    code = SEG_DIGIT[7];
        4'd8:    code = SEG_DIGIT[8];
        4'd9:    code = SEG_DIGIT[9];
        default: code = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg_scan_display.sv
// Eight-digit time-multiplexed display of three counter pages. Value digits
// are snapshotted at the start of every scan frame so a frame never tears.
module seg_scan_display
  import seg7_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int BLANK_LZ    = 1
) (
  input  logic       clk_n,
  input  logic       rst,
  input  logic       page_next,
  input  logic [3:0] wan,
  input  logic [3:0] qian,
  input  logic [3:0] bai,
  input  logic [3:0] shi,
  input  logic [3:0] ge,
  input  logic [3:0] tiao_qian,
  input  logic [3:0] tiao_bai,
  input  logic [3:0] tiao_shi,
  input  logic [3:0] tiao_ge,
  input  logic [3:0] wu_tiao_qian,
  input  logic [3:0] wu_tiao_bai,
  input  logic [3:0] wu_tiao_shi,
  input  logic [3:0] wu_tiao_ge,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic [1:0] page
);

  localparam int             DW       = $clog2(REFRESH_DIV);
  localparam logic [DW-1:0]  DIV_LAST = DW'(REFRESH_DIV - 1);
  localparam logic           LZ_ON    = (BLANK_LZ != 0);

  logic [DW-1:0]  div_q, div_d;
  logic [2:0]     idx_q, idx_d;
  logic [1:0]     page_q, page_d;
  total_digits_t  tot_q, tot_d;
  branch_digits_t cond_q, cond_d;
  branch_digits_t uncond_q, uncond_d;
  logic [7:0]     an_q, an_d;
  logic [6:0]     seg_q, seg_d;

  logic           tick;
  logic           frame_start;
  logic [4:0][3:0] vals;
  logic [4:0]     present;
  logic [4:0]     lz_blank;
  logic           zero_run;
  logic [3:0]     dig_bcd;
  logic           dig_blank;
  logic [6:0]     dig_code;

  assign tick        = (div_q == DIV_LAST);
  assign frame_start = (div_q == '0) && (idx_q == 3'd0);

  // Scan timing, page selection and frame snapshot.
  always_comb begin
    div_d    = tick ? '0 : div_q + 1'b1;
    idx_d    = tick ? idx_q + 3'd1 : idx_q;
    page_d   = page_next ? page_advance(page_q) : page_q;
    tot_d    = tot_q;
    cond_d   = cond_q;
    uncond_d = uncond_q;
    if (frame_start) begin
      tot_d    = '{wan: wan, qian: qian, bai: bai, shi: shi, ge: ge};
      cond_d   = '{qian: tiao_qian, bai: tiao_bai, shi: tiao_shi, ge: tiao_ge};
      uncond_d = '{qian: wu_tiao_qian, bai: wu_tiao_bai, shi: wu_tiao_shi,
                   ge: wu_tiao_ge};
    end
  end

  // Value digits of the current page, slot 0 = ones; absent slots are not
  // value digits and do not stop leading-zero blanking.
  always_comb begin
    vals    = '0;
    present = 5'b00000;
    case (page_q)
      PAGE_COND: begin
        vals[3:0] = {cond_q.qian, cond_q.bai, cond_q.shi, cond_q.ge};
        present   = 5'b01111;
      end
      PAGE_UNCOND: begin
        vals[3:0] = {uncond_q.qian, uncond_q.bai, uncond_q.shi, uncond_q.ge};
        present   = 5'b01111;
      end
      default: begin
        vals    = {tot_q.wan, tot_q.qian, tot_q.bai, tot_q.shi, tot_q.ge};
        present = 5'b11111;
      end
    endcase

    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = 4; i >= 1; i--) begin
      zero_run    = zero_run & ((vals[i] == 4'd0) | ~present[i]);
      lz_blank[i] = zero_run;
    end
  end

  always_comb begin
    dig_bcd   = 4'd0;
    dig_blank = 1'b1;
    case (idx_q)
      3'd7: begin
        dig_bcd   = {2'b00, page_q + 2'd1};
        dig_blank = 1'b0;
      end
      3'd6, 3'd5: begin
        dig_blank = 1'b1;
      end
      default: begin
        dig_bcd   = vals[idx_q];
        dig_blank = ~present[idx_q] | (LZ_ON & lz_blank[idx_q]);
      end
    endcase
  end

  seg7_decode u_decode (
    .bcd   (dig_bcd),
    .blank (dig_blank),
    .code  (dig_code)
  );

  always_comb begin
    an_d  = ~(8'd1 << idx_q);
    seg_d = dig_code;
  end

  always_ff @(posedge clk_n or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      idx_q    <= 3'd0;
      page_q   <= PAGE_TOTAL;
      tot_q    <= '0;
      cond_q   <= '0;
      uncond_q <= '0;
      an_q     <= 8'hFF;
      seg_q    <= SEG_BLANK;
    end else begin
      div_q    <= div_d;
      idx_q    <= idx_d;
      page_q   <= page_d;
      tot_q    <= tot_d;
      cond_q   <= cond_d;
      uncond_q <= uncond_d;
      an_q     <= an_d;
      seg_q    <= seg_d;
    end
  end

  assign an   = an_q;
  assign seg  = seg_q;
  assign dp   = 1'b1;
  assign page = page_q;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (leading-zero blanking on/off)
// checked against a frame-level model of what each digit should show.
module tb_seg_scan_display;

  localparam int R     = 4;
  localparam int FRAME = 8 * R;

  // ---------------- clock / reset ----------------
  logic       clk_n = 1'b0;
  logic       rst;
  logic       page_next;
  logic [3:0] dig [13];
  logic [7:0] an, an2;
  logic [6:0] seg, seg2;
  logic       dp, dp2;
  logic [1:0] page, page2;

  always #5 clk_n = ~clk_n;

  seg_scan_display #(.REFRESH_DIV(R), .BLANK_LZ(1)) dut (
    .clk_n(clk_n), .rst(rst), .page_next(page_next),
    .wan(dig[0]), .qian(dig[1]), .bai(dig[2]), .shi(dig[3]), .ge(dig[4]),
    .tiao_qian(dig[5]), .tiao_bai(dig[6]), .tiao_shi(dig[7]), .tiao_ge(dig[8]),
    .wu_tiao_qian(dig[9]), .wu_tiao_bai(dig[10]), .wu_tiao_shi(dig[11]),
    .wu_tiao_ge(dig[12]),
    .an(an), .seg(seg), .dp(dp), .page(page)
  );

  seg_scan_display #(.REFRESH_DIV(R), .BLANK_LZ(0)) dut_nlz (
    .clk_n(clk_n), .rst(rst), .page_next(page_next),
    .wan(dig[0]), .qian(dig[1]), .bai(dig[2]), .shi(dig[3]), .ge(dig[4]),
    .tiao_qian(dig[5]), .tiao_bai(dig[6]), .tiao_shi(dig[7]), .tiao_ge(dig[8]),
    .wu_tiao_qian(dig[9]), .wu_tiao_bai(dig[10]), .wu_tiao_shi(dig[11]),
    .wu_tiao_ge(dig[12]),
    .an(an2), .seg(seg2), .dp(dp2), .page(page2)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- reference model ----------------
  int         m_t;
  int         m_page;
  int         m_snap [13];
  logic [7:0] exp_an;
  logic [6:0] exp_seg, exp_seg2;
  logic [1:0] exp_page;
  logic [6:0] exp_q [$];

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0: return 7'h40;
      1: return 7'h79;
      2: return 7'h24;
      3: return 7'h30;
      4: return 7'h19;
      5: return 7'h12;
      6: return 7'h02;
      7: return 7'h78;
      8: return 7'h00;
      9: return 7'h10;
      default: return 7'h3F;
    endcase
  endfunction

  // Digit at display position idx (0 = rightmost) for page pg.
  function automatic logic [6:0] ref_code(input int idx, input int pg, input bit lz);
    int base, n, d;
    bit all_zero;
    if (idx == 7) return seg_of(pg + 1);
    if (idx > 4) return 7'h7F;
    base = (pg == 0) ? 0 : (pg == 1) ? 5 : 9;
    n    = (pg == 0) ? 5 : 4;
    if (idx >= n) return 7'h7F;
    d = m_snap[base + n - 1 - idx];
    if (lz && idx > 0) begin
      all_zero = 1'b1;
      for (int k = 0; k <= n - 1 - idx; k++)
        if (m_snap[base + k] != 0) all_zero = 1'b0;
      if (all_zero) return 7'h7F;
    end
    return seg_of(d);
  endfunction

  function automatic logic [3:0] rand_digit();
    if ($urandom_range(0, 5) == 0) return 4'($urandom_range(10, 15));
    return 4'($urandom_range(0, 9));
  endfunction

  task automatic model_reset();
    m_t      = 0;
    m_page   = 0;
    for (int k = 0; k < 13; k++) m_snap[k] = 0;
    exp_an   = 8'hFF;
    exp_seg  = 7'h7F;
    exp_seg2 = 7'h7F;
    exp_page = 2'd0;
  endtask

  // One clock: outputs after the edge show the slot/page/snapshot held
  // before the edge; the snapshot reloads at the start of every frame.
  task automatic tick();
    int idx;
    @(posedge clk_n);
    if (rst) begin
      idx      = (m_t / R) % 8;
      exp_an   = ~(8'd1 << idx);
      exp_seg  = ref_code(idx, m_page, 1'b1);
      exp_seg2 = ref_code(idx, m_page, 1'b0);
      if (m_t % FRAME == 0)
        for (int k = 0; k < 13; k++) m_snap[k] = int'(dig[k]);
      if (page_next) m_page = (m_page + 1) % 3;
      m_t++;
    end
    exp_page = 2'(m_page);
    #1;
  endtask

  task automatic align_frame();
    int guard = 0;
    while (m_t % FRAME != 0 && guard < 2 * FRAME) begin
      tick();
      guard++;
    end
  endtask

  // ---------------- driver / recorder ----------------
  logic [7:0] r_an [64], r_an2 [64], r_xan [64];
  logic [6:0] r_seg [64], r_seg2 [64], r_xseg [64], r_xseg2 [64];
  logic [1:0] r_page [64], r_page2 [64], r_xpage [64], r_dp [64];
  int         n_rec;
  logic [6:0] cap [8], cap2 [8];
  int         hold [8];

  task automatic record(input int n, input bit rand_page, input bit rand_in);
    n_rec = 0;
    for (int s = 0; s < 8; s++) begin
      cap[s] = 'x; cap2[s] = 'x; hold[s] = 0;
    end
    for (int c = 0; c < n; c++) begin
      page_next = rand_page ? ($urandom_range(0, 5) == 0) : 1'b0;
      if (rand_in && $urandom_range(0, 3) == 0) dig[$urandom_range(0, 12)] = rand_digit();
      tick();
      r_an[n_rec] = an;   r_an2[n_rec] = an2;   r_xan[n_rec] = exp_an;
      r_seg[n_rec] = seg; r_seg2[n_rec] = seg2;
      r_xseg[n_rec] = exp_seg; r_xseg2[n_rec] = exp_seg2;
      r_page[n_rec] = page; r_page2[n_rec] = page2; r_xpage[n_rec] = exp_page;
      r_dp[n_rec] = {dp2, dp};
      n_rec++;
      for (int b = 0; b < 8; b++)
        if (an == ~(8'd1 << b)) begin
          cap[b] = seg; cap2[b] = seg2; hold[b]++;
        end
    end
    page_next = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    model_reset();
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < 13; k++) dig[k] = rand_digit();
      page_next = 1'($urandom_range(0, 1));
      @(posedge clk_n); #1;
      n_cmp++;
      if (an !== 8'hFF || seg !== 7'h7F || dp !== 1'b1 || page !== 2'd0 ||
          an2 !== 8'hFF || seg2 !== 7'h7F || dp2 !== 1'b1 || page2 !== 2'd0) begin
        n_fail++;
        $display("FAIL reset_hold: an=%h seg=%h dp=%b page=%0d an2=%h seg2=%h, expected an=ff seg=7f dp=1 page=0",
                 an, seg, dp, page, an2, seg2);
      end
    end
    page_next = 1'b0;
    @(negedge clk_n);
    rst = 1'b1;
    #1;
    n_cmp++;
    if (an !== 8'hFF || seg !== 7'h7F) begin
      n_fail++;
      $display("FAIL reset_release_pre_edge: an=%h seg=%h, expected an=ff seg=7f", an, seg);
    end
    tick();
    n_cmp++;
    if (an !== 8'hFE || seg !== exp_seg || an2 !== 8'hFE || seg2 !== exp_seg2) begin
      n_fail++;
      $display("FAIL reset_first_slot: an=%h seg=%h an2=%h seg2=%h, expected an=fe seg=%h seg2=%h",
               an, seg, an2, seg2, exp_seg, exp_seg2);
    end
  endtask

  task automatic test_scan();
    dig[0] = 4'd1; dig[1] = 4'd2; dig[2] = 4'd3; dig[3] = 4'd4; dig[4] = 4'd5;
    align_frame();
    record(FRAME, 1'b0, 1'b0);
    for (int i = 0; i < n_rec; i++) begin
      n_cmp++;
      if (r_an[i] !== r_xan[i] || r_an2[i] !== r_xan[i] || r_seg[i] !== r_xseg[i] ||
          r_seg2[i] !== r_xseg2[i] || r_page[i] !== r_xpage[i] || r_page2[i] !== r_xpage[i] ||
          r_dp[i] !== 2'b11) begin
        n_fail++;
        $display("FAIL scan_cycle %0d: an=%h seg=%h seg2=%h page=%0d dp=%b, expected an=%h seg=%h seg2=%h page=%0d dp=11",
                 i, r_an[i], r_seg[i], r_seg2[i], r_page[i], r_dp[i], r_xan[i], r_xseg[i], r_xseg2[i], r_xpage[i]);
      end
    end
    for (int s = 0; s < 8; s++) begin
      n_cmp++;
      if (hold[s] !== R) begin
        n_fail++;
        $display("FAIL scan_hold slot %0d: held %0d cycles, expected %0d", s, hold[s], R);
      end
    end
    exp_q = '{seg_of(1), 7'h7F, 7'h7F, seg_of(1), seg_of(2), seg_of(3), seg_of(4), seg_of(5)};
    for (int s = 7; s >= 0; s--) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (cap[s] !== e) begin
        n_fail++;
        $display("FAIL scan_slot %0d: seg=%h, expected %h", s, cap[s], e);
      end
    end
  endtask

  task automatic test_leading_zero();
    for (int pass = 0; pass < 2; pass++) begin
      dig[0] = 4'd0; dig[1] = 4'd0; dig[3] = 4'd0;
      dig[2] = (pass == 0) ? 4'd3 : 4'd0;
      dig[4] = (pass == 0) ? 4'd7 : 4'd0;
      align_frame();
      record(FRAME, 1'b0, 1'b0);
      for (int i = 0; i < n_rec; i++) begin
        n_cmp++;
        if (r_an[i] !== r_xan[i] || r_seg[i] !== r_xseg[i] || r_seg2[i] !== r_xseg2[i] ||
            r_page[i] !== r_xpage[i] || r_dp[i] !== 2'b11) begin
          n_fail++;
          $display("FAIL lz_cycle %0d.%0d: an=%h seg=%h seg2=%h page=%0d, expected an=%h seg=%h seg2=%h page=%0d",
                   pass, i, r_an[i], r_seg[i], r_seg2[i], r_page[i], r_xan[i], r_xseg[i], r_xseg2[i], r_xpage[i]);
        end
      end
      if (pass == 0)
        exp_q = '{seg_of(1), 7'h7F, 7'h7F, 7'h7F, 7'h7F, seg_of(3), seg_of(0), seg_of(7),
                  seg_of(1), 7'h7F, 7'h7F, seg_of(0), seg_of(0), seg_of(3), seg_of(0), seg_of(7)};
      else
        exp_q = '{seg_of(1), 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, seg_of(0),
                  seg_of(1), 7'h7F, 7'h7F, seg_of(0), seg_of(0), seg_of(0), seg_of(0), seg_of(0)};
      for (int s = 7; s >= 0; s--) begin
        logic [6:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (cap[s] !== e) begin
          n_fail++;
          $display("FAIL lz_slot pass %0d slot %0d: seg=%h, expected %h", pass, s, cap[s], e);
        end
      end
      for (int s = 7; s >= 0; s--) begin
        logic [6:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        if (cap2[s] !== e) begin
          n_fail++;
          $display("FAIL nolz_slot pass %0d slot %0d: seg=%h, expected %h", pass, s, cap2[s], e);
        end
      end
    end
  endtask

  task automatic test_tearing();
    // Frame starts with an all-zero page 0 left over from the previous test.
    align_frame();
    record(3 * R, 1'b0, 1'b0);
    for (int k = 0; k < 13; k++) dig[k] = rand_digit();
    dig[0] = 4'($urandom_range(1, 9));
    record(5 * R, 1'b0, 1'b0);
    exp_q = '{seg_of(1), 7'h7F, 7'h7F, 7'h7F, 7'h7F};
    for (int s = 7; s >= 3; s--) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (cap[s] !== e) begin
        n_fail++;
        $display("FAIL tear_old_slot %0d: seg=%h, expected %h", s, cap[s], e);
      end
    end
    record(FRAME, 1'b0, 1'b0);
    for (int i = 0; i < n_rec; i++) begin
      n_cmp++;
      if (r_an[i] !== r_xan[i] || r_seg[i] !== r_xseg[i] || r_seg2[i] !== r_xseg2[i] ||
          r_page[i] !== r_xpage[i]) begin
        n_fail++;
        $display("FAIL tear_cycle %0d: an=%h seg=%h seg2=%h, expected an=%h seg=%h seg2=%h",
                 i, r_an[i], r_seg[i], r_seg2[i], r_xan[i], r_xseg[i], r_xseg2[i]);
      end
    end
    n_cmp++;
    if (cap[0] !== seg_of(int'(dig[4])) || cap[4] !== seg_of(int'(dig[0]))) begin
      n_fail++;
      $display("FAIL tear_new_frame: slot0=%h slot4=%h, expected %h %h",
               cap[0], cap[4], seg_of(int'(dig[4])), seg_of(int'(dig[0])));
    end
  endtask

  task automatic test_page();
    logic [1:0] want [4];
    for (int k = 1; k <= 3; k++) begin
      page_next = 1'b1;
      tick();
      page_next = 1'b0;
      n_cmp++;
      if (page !== 2'(k % 3) || page2 !== 2'(k % 3)) begin
        n_fail++;
        $display("FAIL page_pulse %0d: page=%0d page2=%0d, expected %0d", k, page, page2, k % 3);
      end
      tick(); tick();
    end
    page_next = 1'b1;
    tick();
    page_next = 1'b0;
    dig[5] = 4'd9; dig[6] = 4'd0; dig[7] = 4'd1; dig[8] = 4'd2;
    align_frame();
    record(FRAME, 1'b0, 1'b0);
    exp_q = '{seg_of(2), 7'h7F, 7'h7F, 7'h7F, seg_of(9), seg_of(0), seg_of(1), seg_of(2)};
    for (int s = 7; s >= 0; s--) begin
      logic [6:0] e;
      e = exp_q.pop_front();
      n_cmp++;
      if (cap[s] !== e || cap2[s] !== e) begin
        n_fail++;
        $display("FAIL page1_slot %0d: seg=%h seg2=%h, expected %h", s, cap[s], cap2[s], e);
      end
    end
    // Page pulse on the very edge that opens a frame.
    align_frame();
    for (int k = 0; k < 13; k++) dig[k] = rand_digit();
    page_next = 1'b1;
    tick();
    page_next = 1'b0;
    n_cmp++;
    if (page !== 2'd2) begin
      n_fail++;
      $display("FAIL page_at_frame_start: page=%0d, expected 2", page);
    end
    record(FRAME - 1, 1'b0, 1'b0);
    for (int i = 0; i < n_rec; i++) begin
      n_cmp++;
      if (r_an[i] !== r_xan[i] || r_seg[i] !== r_xseg[i] || r_seg2[i] !== r_xseg2[i] ||
          r_page[i] !== r_xpage[i]) begin
        n_fail++;
        $display("FAIL page_frame_cycle %0d: an=%h seg=%h seg2=%h page=%0d, expected an=%h seg=%h seg2=%h page=%0d",
                 i, r_an[i], r_seg[i], r_seg2[i], r_page[i], r_xan[i], r_xseg[i], r_xseg2[i], r_xpage[i]);
      end
    end
    n_cmp++;
    if (cap[7] !== seg_of(3) || cap[0] !== seg_of(int'(dig[12]))) begin
      n_fail++;
      $display("FAIL page_frame_snapshot: slot7=%h slot0=%h, expected %h %h",
               cap[7], cap[0], seg_of(3), seg_of(int'(dig[12])));
    end
    want = '{2'd0, 2'd1, 2'd2, 2'd0};
    page_next = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      n_cmp++;
      if (page !== want[c]) begin
        n_fail++;
        $display("FAIL page_held %0d: page=%0d, expected %0d", c, page, want[c]);
      end
    end
    page_next = 1'b0;
  endtask

  task automatic test_invalid_digit();
    for (int k = 0; k < 4; k++) dig[k] = 4'($urandom_range(1, 9));
    dig[4] = 4'hC;
    align_frame();
    record(FRAME, 1'b0, 1'b0);
    n_cmp++;
    if (cap[0] !== 7'h3F || cap2[0] !== 7'h3F) begin
      n_fail++;
      $display("FAIL invalid_dash: seg=%h seg2=%h, expected 3f", cap[0], cap2[0]);
    end
  endtask

  task automatic test_random_stream();
    for (int it = 0; it < 5; it++) begin
      for (int k = 0; k < 13; k++) dig[k] = rand_digit();
      record(48, 1'b1, 1'b1);
      for (int i = 0; i < n_rec; i++) begin
        n_cmp++;
        if (r_an[i] !== r_xan[i] || r_an2[i] !== r_xan[i] || r_seg[i] !== r_xseg[i] ||
            r_seg2[i] !== r_xseg2[i] || r_page[i] !== r_xpage[i] || r_page2[i] !== r_xpage[i] ||
            r_dp[i] !== 2'b11) begin
          n_fail++;
          $display("FAIL random_cycle %0d.%0d: an=%h seg=%h seg2=%h page=%0d, expected an=%h seg=%h seg2=%h page=%0d",
                   it, i, r_an[i], r_seg[i], r_seg2[i], r_page[i], r_xan[i], r_xseg[i], r_xseg2[i], r_xpage[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    if (m_page == 0) begin
      page_next = 1'b1;
      tick();
      page_next = 1'b0;
    end
    repeat ($urandom_range(5, 20)) tick();
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    n_cmp++;
    if (an !== 8'hFF || seg !== 7'h7F || page !== 2'd0 || an2 !== 8'hFF ||
        seg2 !== 7'h7F || page2 !== 2'd0) begin
      n_fail++;
      $display("FAIL async_reset: an=%h seg=%h page=%0d an2=%h seg2=%h page2=%0d, expected ff 7f 0",
               an, seg, page, an2, seg2, page2);
    end
    @(negedge clk_n);
    rst = 1'b1;
    record(FRAME, 1'b0, 1'b0);
    for (int i = 0; i < n_rec; i++) begin
      n_cmp++;
      if (r_an[i] !== r_xan[i] || r_seg[i] !== r_xseg[i] || r_seg2[i] !== r_xseg2[i] ||
          r_page[i] !== r_xpage[i]) begin
        n_fail++;
        $display("FAIL post_reset_cycle %0d: an=%h seg=%h seg2=%h page=%0d, expected an=%h seg=%h seg2=%h page=%0d",
                 i, r_an[i], r_seg[i], r_seg2[i], r_page[i], r_xan[i], r_xseg[i], r_xseg2[i], r_xpage[i]);
      end
    end
  endtask

  // ---------------- sequence / report ----------------
  initial begin
    rst = 1'b0;
    page_next = 1'b0;
    for (int k = 0; k < 13; k++) dig[k] = 4'd0;
    test_reset();
    test_scan();
    test_leading_zero();
    test_tearing();
    test_page();
    test_invalid_digit();
    test_random_stream();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, %0d compared / %0d mismatched", n_cmp, n_fail);
    $fatal(1, "watchdog");
  end

endmodule
